// File: rtl/cache_pkg.sv
// Shared state type, field widths and byte helpers for the direct-mapped,
// write-through data cache.
package cache_pkg;

  localparam int WORD_WIDTH         = 32;
  localparam int LANE_WIDTH         = 8;
  localparam int LANES              = WORD_WIDTH / LANE_WIDTH;
  localparam int OFFSET_BITS        = $clog2(LANES);
  localparam int DEFAULT_SETS       = 16;
  localparam int DEFAULT_INDEX_BITS = $clog2(DEFAULT_SETS);
  localparam int DEFAULT_TAG_BITS   = WORD_WIDTH - DEFAULT_INDEX_BITS - OFFSET_BITS;
  localparam int COUNT_WIDTH        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } cache_state_e;

  function automatic logic [LANE_WIDTH-1:0] select_byte(
    input logic [WORD_WIDTH-1:0]  word,
    input logic [OFFSET_BITS-1:0] offset
  );
    logic [LANE_WIDTH-1:0] result;
    result = '0;
    for (int b = 0; b < LANES; b++) begin
      if (offset == OFFSET_BITS'(b)) begin
        result = word[b*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    return result;
  endfunction

  // Word accesses touch every lane; byte accesses touch only the addressed one.
  function automatic logic [LANES-1:0] byte_enable(
    input logic                   byte_op,
    input logic [OFFSET_BITS-1:0] offset
  );
    logic [LANES-1:0] be;
    if (byte_op) begin
      be = LANES'(1) << offset;
    end else begin
      be = '1;
    end
    return be;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] saturating_inc(input logic [COUNT_WIDTH-1:0] value);
    logic [COUNT_WIDTH-1:0] result;
    result = (value == '1) ? value : value + COUNT_WIDTH'(1);
    return result;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the cache lines: combinational lookup, one
// byte-enabled write port, and a global invalidate that clears valid bits only.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int SETS       = DEFAULT_SETS,
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int TAG_BITS   = DEFAULT_TAG_BITS,
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int BYTE_WIDTH = LANE_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             invalidate,
  input  logic [INDEX_BITS-1:0]            lookup_index,
  input  logic [TAG_BITS-1:0]              lookup_tag,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            lookup_data,
  input  logic                             wr_en,
  input  logic [INDEX_BITS-1:0]            wr_index,
  input  logic [TAG_BITS-1:0]              wr_tag,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic [SETS-1:0]     valid_reg;
  logic [SETS-1:0]     valid_next;
  logic [TAG_BITS-1:0] tag_mem [SETS];

  genvar gi;

  generate
    for (gi = 0; gi < SETS; gi++) begin : g_set
      localparam logic [INDEX_BITS-1:0] SET_ID = INDEX_BITS'(gi);
      assign valid_next[gi] = invalidate                         ? 1'b0 :
                              (wr_en && (wr_index == SET_ID))    ? 1'b1 :
                                                                   valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Tags and data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [BYTE_WIDTH-1:0] lane_mem [SETS];

      always_ff @(posedge clk_i) begin
        if (wr_en && wr_be[gi]) begin
          lane_mem[wr_index] <= wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end

      assign lookup_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = lane_mem[lookup_index];
    end
  endgenerate

  assign hit = valid_reg[lookup_index] && (tag_mem[lookup_index] == lookup_tag);

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. Load hits return in the request cycle; misses and stores stall the CPU.
module data_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int SETS       = 16,
  parameter int INDEX_BITS = $clog2(SETS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cpu_re_i,
  input  logic                   cpu_we_i,
  input  logic                   cpu_byte_op_i,
  input  logic [DATA_WIDTH-1:0]  cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]  cpu_wd_i,
  input  logic                   flush_i,
  output logic [DATA_WIDTH-1:0]  cpu_rd_o,
  output logic                   stall_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic                   mem_byte_op_o,
  output logic [DATA_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_wd_o,
  input  logic [DATA_WIDTH-1:0]  mem_rd_i,
  input  logic                   mem_ready_i,
  output logic [COUNT_WIDTH-1:0] hit_count_o,
  output logic [COUNT_WIDTH-1:0] miss_count_o
);

  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int BYTES    = DATA_WIDTH / BYTE_WIDTH;

  cache_state_e           state_reg, state_next;
  logic [COUNT_WIDTH-1:0] hit_count_reg, hit_count_next;
  logic [COUNT_WIDTH-1:0] miss_count_reg, miss_count_next;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic [DATA_WIDTH-1:0]  aligned_addr;
  logic                   hit;
  logic [DATA_WIDTH-1:0]  line_word;
  logic                   invalidate;
  logic                   wr_en;
  logic [BYTES-1:0]       wr_be;
  logic [DATA_WIDTH-1:0]  wr_data;

  assign offset       = cpu_addr_i[OFFSET_BITS-1:0];
  assign index        = cpu_addr_i[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign tag          = cpu_addr_i[DATA_WIDTH-1:INDEX_BITS+OFFSET_BITS];
  assign aligned_addr = {cpu_addr_i[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  function automatic logic [DATA_WIDTH-1:0] format_load(
    input logic [DATA_WIDTH-1:0]  word,
    input logic                   byte_op,
    input logic [OFFSET_BITS-1:0] off
  );
    logic [DATA_WIDTH-1:0] result;
    result = byte_op ? DATA_WIDTH'(select_byte(word, off)) : word;
    return result;
  endfunction

  cache_line_array #(
    .SETS       (SETS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_lines (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .invalidate   (invalidate),
    .lookup_index (index),
    .lookup_tag   (tag),
    .hit          (hit),
    .lookup_data  (line_word),
    .wr_en        (wr_en),
    .wr_index     (index),
    .wr_tag       (tag),
    .wr_be        (wr_be),
    .wr_data      (wr_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      hit_count_reg  <= hit_count_next;
      miss_count_reg <= miss_count_next;
    end
  end

  // The CPU holds its request stable while stalled, so the index/tag seen in
  // FETCH and WRITE are still those of the request accepted in IDLE.
  always_comb begin
    state_next      = state_reg;
    stall_o         = 1'b0;
    cpu_rd_o        = '0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_byte_op_o   = 1'b0;
    mem_addr_o      = aligned_addr;
    mem_wd_o        = cpu_wd_i;
    invalidate      = 1'b0;
    wr_en           = 1'b0;
    wr_be           = '1;
    wr_data         = mem_rd_i;
    hit_count_next  = hit_count_reg;
    miss_count_next = miss_count_reg;

    unique case (state_reg)
      IDLE: begin
        if (flush_i) begin
          invalidate = 1'b1;
          stall_o    = 1'b1;
        end else if (cpu_we_i) begin
          stall_o    = 1'b1;
          state_next = WRITE;
        end else if (cpu_re_i) begin
          if (hit) begin
            cpu_rd_o       = format_load(line_word, cpu_byte_op_i, offset);
            hit_count_next = saturating_inc(hit_count_reg);
          end else begin
            stall_o         = 1'b1;
            miss_count_next = saturating_inc(miss_count_reg);
            state_next      = FETCH;
          end
        end
      end

      FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          wr_en      = 1'b1;
          cpu_rd_o   = format_load(mem_rd_i, cpu_byte_op_i, offset);
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end

      WRITE: begin
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        mem_byte_op_o = cpu_byte_op_i;
        mem_addr_o    = cpu_byte_op_i ? cpu_addr_i : aligned_addr;
        if (mem_ready_i) begin
          // No allocation on a store miss; a hit keeps the line coherent with memory.
          wr_en      = hit;
          wr_be      = byte_enable(cpu_byte_op_i, offset);
          wr_data    = cpu_byte_op_i ? {BYTES{cpu_wd_i[BYTE_WIDTH-1:0]}} : cpu_wd_i;
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign hit_count_o  = hit_count_reg;
  assign miss_count_o = miss_count_reg;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized
// loads/stores/flushes against a behavioural memory + residency model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_re_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic        cpu_byte_op_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wd_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] cpu_rd_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        mem_byte_op_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  always #5 clk = ~clk;

  data_cache #(
    .DATA_WIDTH (32),
    .BYTE_WIDTH (8),
    .SETS       (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cpu_re_i      (cpu_re_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_byte_op_i (cpu_byte_op_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_wd_i      (cpu_wd_i),
    .flush_i       (flush_i),
    .cpu_rd_o      (cpu_rd_o),
    .stall_o       (stall_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_byte_op_o (mem_byte_op_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wd_o      (mem_wd_o),
    .mem_rd_i      (mem_rd_i),
    .mem_ready_i   (mem_ready_i),
    .hit_count_o   (hit_count_o),
    .miss_count_o  (miss_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Backing store seen by the DUT, and the bench's own view of what memory should hold.
  logic [31:0] bench_mem [bit [31:0]];
  logic [31:0] ref_mem   [bit [31:0]];
  // Which word address occupies each direct-mapped slot (absent = invalid).
  bit   [31:0] resident  [int];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  int ready_delay = 0;
  int wait_cnt    = 0;

  logic [31:0] got_rd;
  logic [31:0] got_req_addr;
  int          got_stalls;
  bit          got_req, got_stable, got_we, got_byte_op, got_timeout;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] bench_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return bench_mem.exists(w) ? bench_mem[w] : mem_default(w);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ref_mem.exists(w) ? ref_mem[w] : mem_default(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic byte_op, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (byte_op) r[8*off +: 8] = wd[7:0];
    else         r = wd;
    return r;
  endfunction

  // Memory responder: ready after ready_delay wait cycles; writes land when ready.
  always @(negedge clk) begin
    #1;
    if (mem_req_o === 1'b1) begin
      if (wait_cnt < ready_delay) begin
        mem_ready_i = 1'b0;
        wait_cnt++;
      end else begin
        mem_ready_i = 1'b1;
        wait_cnt    = 0;
        if (mem_we_o === 1'b1)
          bench_mem[{mem_addr_o[31:2], 2'b00}] = merge(bench_read(mem_addr_o), mem_wd_o,
                                                      mem_byte_op_o, mem_addr_o[1:0]);
      end
      mem_rd_i = bench_read(mem_addr_o);
    end else begin
      mem_ready_i = 1'b0;
      wait_cnt    = 0;
      mem_rd_i    = 32'h0;
    end
  end

  task automatic model_load(input logic [31:0] addr, input bit byte_op, input int delay,
                            output logic [31:0] exp_rd, output int exp_stalls);
    int          idx;
    logic [31:0] waddr, w;
    idx   = int'(addr[5:2]);
    waddr = {addr[31:2], 2'b00};
    w     = ref_read(addr);
    if (resident.exists(idx) && resident[idx] == waddr) begin
      exp_hits++;
      exp_stalls = 0;
    end else begin
      exp_misses++;
      resident[idx] = waddr;
      exp_stalls    = 1 + delay;
    end
    exp_rd = byte_op ? {24'h0, w[8*addr[1:0] +: 8]} : w;
  endtask

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input bit byte_op);
    ref_mem[{addr[31:2], 2'b00}] = merge(ref_read(addr), wd, byte_op, addr[1:0]);
  endtask

  task automatic run_op(input bit we, input bit re, input bit byte_op,
                        input logic [31:0] addr, input logic [31:0] wd, input int delay);
    ready_delay = delay;
    @(negedge clk);
    cpu_we_i = we; cpu_re_i = re; cpu_byte_op_i = byte_op; cpu_addr_i = addr; cpu_wd_i = wd;
    got_stalls = 0; got_req = 0; got_stable = 1; got_we = 0; got_byte_op = 0;
    got_timeout = 1; got_rd = 'x; got_req_addr = '0;
    for (int c = 0; c < 64; c++) begin
      #2;
      if (mem_req_o === 1'b1) begin
        if (!got_req) got_req_addr = mem_addr_o;
        else if (mem_addr_o !== got_req_addr) got_stable = 0;
        got_req = 1; got_we = mem_we_o; got_byte_op = mem_byte_op_o;
      end
      if (stall_o === 1'b0) begin
        got_rd = cpu_rd_o;
        got_timeout = 0;
        break;
      end
      got_stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    cpu_we_i = 0; cpu_re_i = 0; cpu_byte_op_i = 0;
    #2;
    $display("op we=%0b re=%0b byte=%0b addr=%h wd=%h rd=%h stalls=%0d req=%0b timeout=%0b",
             we, re, byte_op, addr, wd, got_rd, got_stalls, got_req, got_timeout);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we_o); end
    n_checks++; if (cpu_rd_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd got=%h exp=0", cpu_rd_o); end
    n_checks++; if (hit_count_o !== 32'h0) begin n_fail++; $display("FAIL reset_hits got=%0d exp=0", hit_count_o); end
    n_checks++; if (miss_count_o !== 32'h0) begin n_fail++; $display("FAIL reset_misses got=%0d exp=0", miss_count_o); end
    rst_ni = 1'b1;
    $display("reset released");
  endtask

  task automatic test_load_fill_hit;
    logic [31:0] exp_rd;
    int          exp_st;
    run_op(0, 1, 0, 32'h0001_0000, 0, 0);
    model_load(32'h0001_0000, 0, 0, exp_rd, exp_st);
    n_checks++; if (got_timeout) begin n_fail++; $display("FAIL lw_miss_timeout got=timeout exp=completion"); end
    n_checks++; if (got_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_miss_data got=%h exp=deadbeef", got_rd); end
    n_checks++; if (got_stalls != 1) begin n_fail++; $display("FAIL lw_miss_stalls got=%0d exp=1", got_stalls); end
    n_checks++; if (got_req_addr !== 32'h0001_0000) begin n_fail++; $display("FAIL lw_fetch_addr got=%h exp=00010000", got_req_addr); end
    n_checks++; if (miss_count_o !== 32'd1) begin n_fail++; $display("FAIL lw_miss_count got=%0d exp=1", miss_count_o); end
    run_op(0, 1, 0, 32'h0001_0000, 0, 0);
    model_load(32'h0001_0000, 0, 0, exp_rd, exp_st);
    n_checks++; if (got_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_hit_data got=%h exp=deadbeef", got_rd); end
    n_checks++; if (got_stalls != 0) begin n_fail++; $display("FAIL lw_hit_stalls got=%0d exp=0", got_stalls); end
    n_checks++; if (got_req) begin n_fail++; $display("FAIL lw_hit_mem_req got=1 exp=0"); end
    n_checks++; if (hit_count_o !== 32'd1) begin n_fail++; $display("FAIL lw_hit_count got=%0d exp=1", hit_count_o); end
    run_op(0, 1, 1, 32'h0001_0002, 0, 0);
    model_load(32'h0001_0002, 1, 0, exp_rd, exp_st);
    n_checks++; if (got_rd !== 32'h0000_00AD || got_stalls != 0) begin n_fail++; $display("FAIL lbu2 got=%h/%0d exp=000000ad/0", got_rd, got_stalls); end
    run_op(0, 1, 1, 32'h0001_0003, 0, 0);
    model_load(32'h0001_0003, 1, 0, exp_rd, exp_st);
    n_checks++; if (got_rd !== 32'h0000_00DE || got_stalls != 0) begin n_fail++; $display("FAIL lbu3 got=%h/%0d exp=000000de/0", got_rd, got_stalls); end
  endtask

  task automatic test_byte_store;
    logic [31:0] exp_rd;
    int          exp_st;
    run_op(1, 0, 1, 32'h0001_0001, 32'h0000_0055, 0);
    model_store(32'h0001_0001, 32'h0000_0055, 1);
    n_checks++; if (got_stalls != 1) begin n_fail++; $display("FAIL sb_stalls got=%0d exp=1", got_stalls); end
    n_checks++; if (!got_we || !got_byte_op) begin n_fail++; $display("FAIL sb_mem_ctrl got=we%0b/byte%0b exp=we1/byte1", got_we, got_byte_op); end
    n_checks++; if (got_req_addr !== 32'h0001_0001) begin n_fail++; $display("FAIL sb_mem_addr got=%h exp=00010001", got_req_addr); end
    run_op(0, 1, 0, 32'h0001_0000, 0, 0);
    model_load(32'h0001_0000, 0, 0, exp_rd, exp_st);
    n_checks++; if (got_rd !== 32'hDEAD_55EF || got_stalls != 0) begin n_fail++; $display("FAIL sb_then_lw got=%h/%0d exp=dead55ef/0", got_rd, got_stalls); end
    n_checks++; if (bench_read(32'h0001_0000) !== 32'hDEAD_55EF) begin n_fail++; $display("FAIL sb_memory got=%h exp=dead55ef", bench_read(32'h0001_0000)); end
  endtask

  task automatic test_conflict;
    logic [31:0] exp_rd;
    int          exp_st;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0001_0040; addrs[1] = 32'h0001_0000; addrs[2] = 32'h0001_0040;
    for (int i = 0; i < 3; i++) begin
      run_op(0, 1, 0, addrs[i], 0, 0);
      model_load(addrs[i], 0, 0, exp_rd, exp_st);
      n_checks++;
      if (got_stalls != 1 || got_rd !== exp_rd) begin
        n_fail++; $display("FAIL conflict_%0d got=%h/%0d exp=%h/1", i, got_rd, got_stalls, exp_rd);
      end
    end
    n_checks++; if (miss_count_o !== 32'(exp_misses)) begin n_fail++; $display("FAIL conflict_misses got=%0d exp=%0d", miss_count_o, exp_misses); end
  endtask

  task automatic test_fetch_wait_reset;
    logic [31:0] exp_rd;
    int          exp_st;
    run_op(0, 1, 0, 32'h0002_0000, 0, 3);
    model_load(32'h0002_0000, 0, 3, exp_rd, exp_st);
    n_checks++; if (got_stalls != 4) begin n_fail++; $display("FAIL wait_stalls got=%0d exp=4", got_stalls); end
    n_checks++; if (!got_stable || got_req_addr !== 32'h0002_0000) begin n_fail++; $display("FAIL wait_addr got=%h stable=%0b exp=00020000 stable=1", got_req_addr, got_stable); end
    n_checks++; if (got_rd !== exp_rd) begin n_fail++; $display("FAIL wait_data got=%h exp=%h", got_rd, exp_rd); end
    // Abandon a fetch part-way through with a reset.
    ready_delay = 3;
    @(negedge clk); cpu_re_i = 1; cpu_byte_op_i = 0; cpu_addr_i = 32'h0003_0000;
    @(negedge clk); #2;
    n_checks++; if (mem_req_o !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL abort_fetch_active got=req%b/stall%b exp=1/1", mem_req_o, stall_o); end
    @(negedge clk); rst_ni = 0; cpu_re_i = 0;
    @(negedge clk); #2;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL abort_mem_req got=%b exp=0", mem_req_o); end
    n_checks++; if (miss_count_o !== 32'h0 || hit_count_o !== 32'h0) begin n_fail++; $display("FAIL abort_counters got=%0d/%0d exp=0/0", hit_count_o, miss_count_o); end
    rst_ni = 1;
    $display("reset during fetch released");
    resident.delete(); exp_hits = 0; exp_misses = 0;
    run_op(0, 1, 0, 32'h0003_0000, 0, 0);
    model_load(32'h0003_0000, 0, 0, exp_rd, exp_st);
    n_checks++; if (got_stalls != 1 || got_rd !== exp_rd) begin n_fail++; $display("FAIL abort_line_invalid got=%h/%0d exp=%h/1", got_rd, got_stalls, exp_rd); end
    n_checks++; if (miss_count_o !== 32'd1) begin n_fail++; $display("FAIL abort_miss_count got=%0d exp=1", miss_count_o); end
  endtask

  task automatic test_flush_and_dual;
    logic [31:0] exp_rd;
    int          exp_st;
    run_op(0, 1, 0, 32'h0001_0000, 0, 0);
    model_load(32'h0001_0000, 0, 0, exp_rd, exp_st);
    n_checks++; if (got_rd !== exp_rd || got_stalls != exp_st) begin n_fail++; $display("FAIL preflush_lw got=%h/%0d exp=%h/%0d", got_rd, got_stalls, exp_rd, exp_st); end
    @(negedge clk); flush_i = 1; cpu_re_i = 1; cpu_addr_i = 32'h0001_0000;
    #2;
    n_checks++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle got=stall%b/req%b exp=1/0", stall_o, mem_req_o); end
    @(negedge clk); flush_i = 0; cpu_re_i = 0;
    #2;
    $display("flush pulse issued");
    resident.delete();
    n_checks++; if (hit_count_o !== 32'(exp_hits)) begin n_fail++; $display("FAIL flush_no_accept got=%0d exp=%0d", hit_count_o, exp_hits); end
    run_op(0, 1, 0, 32'h0001_0000, 0, 0);
    model_load(32'h0001_0000, 0, 0, exp_rd, exp_st);
    n_checks++; if (got_stalls != 1 || got_rd !== exp_rd) begin n_fail++; $display("FAIL postflush_miss got=%h/%0d exp=%h/1", got_rd, got_stalls, exp_rd); end
    run_op(1, 1, 0, 32'h0001_0000, 32'h1234_5678, 0);
    model_store(32'h0001_0000, 32'h1234_5678, 0);
    n_checks++; if (got_stalls != 1 || !got_we) begin n_fail++; $display("FAIL dual_store got=%0d/we%0b exp=1/we1", got_stalls, got_we); end
    n_checks++; if (hit_count_o !== 32'(exp_hits) || miss_count_o !== 32'(exp_misses)) begin n_fail++; $display("FAIL dual_counters got=%0d/%0d exp=%0d/%0d", hit_count_o, miss_count_o, exp_hits, exp_misses); end
    run_op(0, 1, 0, 32'h0001_0000, 0, 0);
    model_load(32'h0001_0000, 0, 0, exp_rd, exp_st);
    n_checks++; if (got_rd !== 32'h1234_5678 || got_stalls != 0) begin n_fail++; $display("FAIL dual_readback got=%h/%0d exp=12345678/0", got_rd, got_stalls); end
  endtask

  task automatic test_random;
    logic [31:0] exp_rd, addr, wd;
    int          exp_st, kind, delay;
    for (int n = 0; n < 250; n++) begin
      kind  = $urandom_range(0, 9);
      delay = $urandom_range(0, 2);
      addr  = 32'h0004_0000 + (32'($urandom_range(0, 2)) << 6) + (32'($urandom_range(0, 3)) << 2);
      wd    = $urandom;
      if (kind <= 3) begin
        run_op(0, 1, 0, addr, 0, delay);
        model_load(addr, 0, delay, exp_rd, exp_st);
      end else if (kind <= 5) begin
        addr[1:0] = 2'($urandom_range(0, 3));
        run_op(0, 1, 1, addr, 0, delay);
        model_load(addr, 1, delay, exp_rd, exp_st);
      end else if (kind <= 8) begin
        if (kind == 8) addr[1:0] = 2'($urandom_range(0, 3));
        run_op(1, bit'($urandom_range(0, 1)), kind == 8, addr, wd, delay);
        model_store(addr, wd, kind == 8);
        exp_st = 1 + delay;
      end else begin
        @(negedge clk); flush_i = 1;
        @(negedge clk); flush_i = 0;
        #2;
        $display("op flush");
        resident.delete();
        continue;
      end
      n_checks++;
      if (got_timeout || got_stalls != exp_st) begin
        n_fail++; $display("FAIL rand_stalls op=%0d addr=%h got=%0d exp=%0d", n, addr, got_stalls, exp_st);
      end
      if (kind <= 5) begin
        n_checks++;
        if (got_rd !== exp_rd) begin
          n_fail++; $display("FAIL rand_load op=%0d addr=%h got=%h exp=%h", n, addr, got_rd, exp_rd);
        end
      end
    end
    n_checks++; if (hit_count_o !== 32'(exp_hits)) begin n_fail++; $display("FAIL rand_hits got=%0d exp=%0d", hit_count_o, exp_hits); end
    n_checks++; if (miss_count_o !== 32'(exp_misses)) begin n_fail++; $display("FAIL rand_misses got=%0d exp=%0d", miss_count_o, exp_misses); end
  endtask

  initial begin
    bench_mem[32'h0001_0000] = 32'hDEAD_BEEF;
    ref_mem[32'h0001_0000]   = 32'hDEAD_BEEF;
    test_reset();
    test_load_fill_hit();
    test_byte_store();
    test_conflict();
    test_fetch_wait_reset();
    test_flush_and_dual();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
